// File: rtl/replay_unit_if.sv
// Val/rdy message channel. The producer of msg/val uses master; the consumer,
// which drives rdy, uses slave.
interface replay_unit_if #(
   parameter int p_msg_nbits = 32
) ();
   logic [p_msg_nbits-1:0] msg;
   logic                   val;
   logic                   rdy;

   modport master (output msg, output val, input rdy);
   modport slave  (input msg, input val, output rdy);
endinterface

// File: rtl/replay_unit.sv
// Val/rdy stream element that re-sends the most recently delivered message once
// per replay request and stalls new input until the queued replays have drained.
module replay_unit #(
   parameter  int p_msg_nbits   = 32,
   parameter  int p_max_pending = 3,
   localparam int CW            = $clog2(p_max_pending + 1)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                replay,
   replay_unit_if.slave        in,
   replay_unit_if.master       out,
   output logic [CW-1:0]       pending
);

   logic                   hist_val;
   logic [p_msg_nbits-1:0] hist_msg;
   logic                   replay_mode;
   logic                   xfer;
   logic                   inc;
   logic                   dec;

   assign replay_mode = (pending != '0);

   // REPLAY owns the output and stalls upstream; PASS is a plain wire-through.
   always_comb begin
      out.val = in.val;
      out.msg = in.msg;
      in.rdy  = out.rdy;
      if (replay_mode) begin
         out.val = 1'b1;
         out.msg = hist_msg;
         in.rdy  = 1'b0;
      end
   end

   assign xfer = out.val && out.rdy;
   // A request at saturation is dropped, so a concurrent replay transfer still decrements.
   assign inc  = replay && hist_val && (pending < CW'(p_max_pending));
   assign dec  = replay_mode && xfer;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending  <= '0;
         hist_val <= 1'b0;
         hist_msg <= '0;
      end else begin
         pending <= pending + CW'(inc) - CW'(dec);
         if (xfer && !replay_mode) begin
            hist_msg <= in.msg;
            hist_val <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_replay_unit.sv
// Directed bench for replay_unit: pass-through, replay ordering, saturation,
// backpressure, same-cycle request/transfer and asynchronous reset.
module tb_replay_unit;
   localparam int W  = 32;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          replay;
   logic [CW-1:0] pending;
   int            vec = 0;
   int            err = 0;

   replay_unit_if #(.p_msg_nbits(W)) in_if ();
   replay_unit_if #(.p_msg_nbits(W)) out_if ();

   replay_unit #(.p_msg_nbits(W), .p_max_pending(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .replay  (replay),
      .in      (in_if),
      .out     (out_if),
      .pending (pending)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs change and checks run mid-cycle.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; replay = 1'b0; in_if.val = 1'b0; in_if.msg = '0; out_if.rdy = 1'b0;
      #12;
      vec++; if (pending !== 2'd0) begin err++; $display("FAIL reset_pending: got %0d want 0", pending); end
      vec++; if (out_if.val !== 1'b0) begin err++; $display("FAIL reset_out_val: got %b want 0", out_if.val); end
      reset_n = 1'b1;
      tick();
      in_if.val = 1'b1; in_if.msg = 32'h1111; out_if.rdy = 1'b1;
      #1;
      vec++; if (out_if.val !== 1'b1) begin err++; $display("FAIL pass_val: got %b want 1", out_if.val); end
      vec++; if (out_if.msg !== 32'h1111) begin err++; $display("FAIL pass_msg: got %h want 00001111", out_if.msg); end
      vec++; if (in_if.rdy !== 1'b1) begin err++; $display("FAIL pass_rdy: got %b want 1", in_if.rdy); end
      in_if.val = 1'b0;
   endtask

   task automatic test_no_history();
      replay = 1'b1;
      tick();
      replay = 1'b0;
      #1;
      vec++; if (pending !== 2'd0) begin err++; $display("FAIL nohist_pending: got %0d want 0", pending); end
      vec++; if (in_if.rdy !== 1'b1) begin err++; $display("FAIL nohist_rdy: got %b want 1", in_if.rdy); end
      vec++; if (out_if.val !== 1'b0) begin err++; $display("FAIL nohist_val: got %b want 0", out_if.val); end
   endtask

   task automatic test_replay_basic();
      in_if.val = 1'b1; in_if.msg = 32'h2222; out_if.rdy = 1'b1;
      tick();
      in_if.msg = 32'h3333; out_if.rdy = 1'b0; replay = 1'b1;
      tick();
      replay = 1'b0; out_if.rdy = 1'b1;
      #1;
      vec++; if (pending !== 2'd1) begin err++; $display("FAIL basic_pending: got %0d want 1", pending); end
      vec++; if (out_if.msg !== 32'h2222) begin err++; $display("FAIL basic_msg: got %h want 00002222", out_if.msg); end
      vec++; if (out_if.val !== 1'b1) begin err++; $display("FAIL basic_val: got %b want 1", out_if.val); end
      vec++; if (in_if.rdy !== 1'b0) begin err++; $display("FAIL basic_rdy: got %b want 0", in_if.rdy); end
      tick();
      #1;
      vec++; if (pending !== 2'd0) begin err++; $display("FAIL basic_exit_pending: got %0d want 0", pending); end
      vec++; if (out_if.msg !== 32'h3333) begin err++; $display("FAIL basic_exit_msg: got %h want 00003333", out_if.msg); end
      vec++; if (in_if.rdy !== 1'b1) begin err++; $display("FAIL basic_exit_rdy: got %b want 1", in_if.rdy); end
      tick();
      in_if.val = 1'b0;
   endtask

   task automatic test_saturate();
      logic [CW-1:0] exp_p;
      in_if.val = 1'b1; in_if.msg = 32'h4444; out_if.rdy = 1'b1;
      tick();
      in_if.msg = 32'h5555; out_if.rdy = 1'b0; replay = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         exp_p = (i > 3) ? 2'd3 : CW'(i);
         vec++; if (pending !== exp_p) begin err++; $display("FAIL sat_fill%0d: got %0d want %0d", i, pending, exp_p); end
      end
      replay = 1'b0; out_if.rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         vec++; if (out_if.msg !== 32'h4444 || out_if.val !== 1'b1 || in_if.rdy !== 1'b0) begin
            err++; $display("FAIL sat_drain%0d: got msg %h val %b rdy %b want 00004444 1 0", i, out_if.msg, out_if.val, in_if.rdy);
         end
         tick();
      end
      #1;
      vec++; if (pending !== 2'd0) begin err++; $display("FAIL sat_exit_pending: got %0d want 0", pending); end
      vec++; if (out_if.msg !== 32'h5555 || in_if.rdy !== 1'b1) begin
         err++; $display("FAIL sat_exit_pass: got msg %h rdy %b want 00005555 1", out_if.msg, in_if.rdy);
      end
      in_if.val = 1'b0;
   endtask

   task automatic test_backpressure();
      tick();
      in_if.val = 1'b1; in_if.msg = 32'h6666; out_if.rdy = 1'b1;
      tick();
      in_if.val = 1'b0; in_if.msg = 32'h7777; out_if.rdy = 1'b0; replay = 1'b1;
      tick();
      replay = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         vec++; if (pending !== 2'd1 || out_if.msg !== 32'h6666 || out_if.val !== 1'b1) begin
            err++; $display("FAIL bp_hold%0d: got p %0d msg %h val %b want 1 00006666 1", i, pending, out_if.msg, out_if.val);
         end
      end
      replay = 1'b1; out_if.rdy = 1'b1;
      tick();
      replay = 1'b0;
      vec++; if (pending !== 2'd1) begin err++; $display("FAIL bp_req_xfer: got %0d want 1", pending); end
      tick();
      vec++; if (pending !== 2'd0) begin err++; $display("FAIL bp_drain: got %0d want 0", pending); end
   endtask

   task automatic test_reset_mid_replay();
      out_if.rdy = 1'b0; replay = 1'b1;
      tick();
      tick();
      replay = 1'b0;
      vec++; if (pending !== 2'd2) begin err++; $display("FAIL rst_setup: got %0d want 2", pending); end
      #1;
      reset_n = 1'b0; in_if.val = 1'b1; in_if.msg = 32'h8888;
      #1;
      vec++; if (pending !== 2'd0) begin err++; $display("FAIL rst_async_pending: got %0d want 0", pending); end
      vec++; if (out_if.val !== 1'b1 || out_if.msg !== 32'h8888 || in_if.rdy !== 1'b0) begin
         err++; $display("FAIL rst_async_pass: got val %b msg %h rdy %b want 1 00008888 0", out_if.val, out_if.msg, in_if.rdy);
      end
      #1;
      reset_n = 1'b1; in_if.val = 1'b0; replay = 1'b1;
      tick();
      replay = 1'b0;
      vec++; if (pending !== 2'd0) begin err++; $display("FAIL rst_hist_cleared: got %0d want 0", pending); end
   endtask

   task automatic test_back_to_back();
      in_if.val = 1'b1; in_if.msg = 32'hAAAA; out_if.rdy = 1'b1;
      tick();
      in_if.msg = 32'hBBBB; replay = 1'b1;
      tick();
      replay = 1'b0; in_if.msg = 32'hCCCC;
      #1;
      vec++; if (pending !== 2'd1 || out_if.msg !== 32'hBBBB) begin
         err++; $display("FAIL b2b_repeat_new: got p %0d msg %h want 1 0000bbbb", pending, out_if.msg);
      end
      tick();
      vec++; if (pending !== 2'd0 || out_if.msg !== 32'hCCCC) begin
         err++; $display("FAIL b2b_exit: got p %0d msg %h want 0 0000cccc", pending, out_if.msg);
      end
      in_if.val = 1'b0;
   endtask

   initial begin
      test_reset();
      test_no_history();
      test_replay_basic();
      test_saturate();
      test_backpressure();
      test_reset_mid_replay();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
